mmul_dot_accumulator: RTL and testbench
=======================================

Name: mmul_dot_accumulator

Overview:
- Downstream consumer of the signed-product multiplier stage. Receives one product per beat over a valid/ready handshake and accumulates products into a signed dot-product sum.
- Emits the finished sum, a beat count and an overflow flag when the upstream marks the last product of a group.
- A registered output slot lets accumulation of the next group overlap with the downstream holding the previous result.

Parameters:
- RES_WIDTH, 10, width of the incoming product. Always two's-complement signed, since the multiplier sign-extends both operands.
- ACC_WIDTH, 24, accumulator and output sum width. Must be >= RES_WIDTH.
- CNT_WIDTH, 8, width of the per-group beat counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_prod  input  RES_WIDTH  signed product from the multiplier
- in_last  input  1  beat is the final product of the current group
- acc_clr  input  1  abort the current group; accumulator and counter go to zero
- out_valid  output  1  result slot holds a finished group
- out_ready  input  1  downstream accepts the result
- out_sum  output  ACC_WIDTH  signed group sum
- out_count  output  CNT_WIDTH  number of beats in the group (saturating)
- out_ovf  output  1  signed overflow occurred at least once during the group

Behaviour:
- Reset (rst=1 at a rising edge):
  - acc=0, cnt=0, ovf_acc=0, state=EMPTY.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Reset mid-group discards the partial sum and any pending result.
- Handshake:
  - in_ready = !out_valid | out_ready. Purely registered-state and out_ready driven; never depends on in_valid.
  - A beat is accepted when in_valid & in_ready. An output transfer happens when out_valid & out_ready.
- Arithmetic:
  - in_prod is sign-extended to ACC_WIDTH; acc_next = acc + sext(in_prod).
  - The sum wraps modulo 2^ACC_WIDTH.
  - Signed overflow is when both operand signs are equal and the result sign differs. It sets the sticky ovf_acc for the group.
  - cnt increments per accepted beat and saturates at 2^CNT_WIDTH-1.
- State machine:
  - EMPTY (acc=0, cnt=0): an accepted non-last beat goes to PARTIAL.
  - PARTIAL: an accepted non-last beat stays in PARTIAL.
  - From either state, an accepted last beat:
    - loads out_sum=acc_next, out_count=cnt+1 (saturated), out_ovf=ovf_acc|ovf_this_beat;
    - sets out_valid=1 on the next cycle;
    - clears acc, cnt and ovf_acc; returns to EMPTY.
- Latency:
  - The last beat accepted at edge t gives out_valid=1 after edge t; the sum includes that beat.
  - A single-beat group yields out_sum = sext(in_prod), out_count=1.
- Output slot:
  - out_sum, out_count and out_ovf are held stable while out_valid & !out_ready.
  - out_valid clears after a transfer unless a new last beat is accepted on the same edge, in which case the slot reloads and out_valid stays 1 (back-to-back results, full throughput).
- Non-last beats while out_valid & !out_ready: in_ready=0, so they stall. This conservative rule is fixed.
- acc_clr:
  - Has priority over any beat accepted on the same edge; that beat is dropped.
  - Clears acc, cnt and ovf_acc and goes to EMPTY.
  - Does not touch the output slot.
  - in_ready is unaffected, so the upstream sees the beat as consumed.
- A pending result is never overwritten without a transfer.

Test Plan:
- Reset then group {+7, -3, +25, -1} (last on 4th), out_ready=1 -> one cycle after the last beat: out_valid=1, out_sum=28, out_count=4, out_ovf=0; next cycle out_valid=0.
- Single-beat group in_prod=10'h200 (-512), last=1 -> out_sum=-512 sign-extended (24'hFFFE00), out_count=1.
- Backpressure: out_ready=0 after group A (sum 5) completes; group B beats arrive -> in_ready=0, out_sum stays 5. Raise out_ready -> A transfers, B accumulates, B result correct.
- Back-to-back single-beat groups 3,4,5 with out_ready=1 -> out_valid held 1 for 3 consecutive cycles with sums 3,4,5; no beat lost.
- Overflow with ACC_WIDTH=12: accumulate +511 nine times (4599 > 2047) -> out_ovf=1, out_sum = 4599 mod 4096 = 503. The next group's out_ovf=0.
- acc_clr asserted with an accepted beat mid-group, then group {2,3} -> out_sum=5, out_count=2. rst asserted while out_valid=1 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/mmul_dot_accumulator_if.sv
// Product-beat and result-slot handshake bundle for the dot-product accumulator.
// master drives beats and out_ready; slave is the accumulator.
interface mmul_dot_accumulator_if #(
    parameter int RES_WIDTH = 10,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [RES_WIDTH-1:0] in_prod;
    logic                 in_last;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_prod, in_last, acc_clr, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, acc_clr, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/mmul_dot_accumulator.sv
// Signed dot-product accumulator behind the multiplier stage.
// One registered result slot lets the next group accumulate while a result waits.
module mmul_dot_accumulator #(
    parameter int RES_WIDTH = 10,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    mmul_dot_accumulator_if.slave bus
);
    typedef enum logic [0:0] {EMPTY, PARTIAL} state_t;

    state_t               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;
    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] out_sum_q;
    logic [CNT_WIDTH-1:0] out_count_q;
    logic                 out_ovf_q;

    logic [ACC_WIDTH-1:0] acc_base;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 ovf_beat;
    logic                 ovf_d;
    logic                 in_ready;
    logic                 beat;
    logic                 xfer;

    // Handshake: the slot frees when empty or draining this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign beat     = bus.in_valid && in_ready;
    assign xfer     = out_valid_q && bus.out_ready;

    // Next accumulator, saturating count and sticky overflow for this beat.
    always_comb begin
        acc_base = (state_q == EMPTY) ? '0 : acc_q;
        cnt_base = (state_q == EMPTY) ? '0 : cnt_q;
        prod_ext = ACC_WIDTH'($signed(bus.in_prod));
        acc_d    = acc_base + prod_ext;
        ovf_beat = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (acc_d[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
        ovf_d    = ((state_q == EMPTY) ? 1'b0 : ovf_q) || ovf_beat;
        cnt_d    = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
    end

    // Group FSM plus registered result slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b0;
            end
            if (bus.acc_clr) begin
                state_q <= EMPTY;
                acc_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else if (beat) begin
                if (bus.in_last) begin
                    out_valid_q <= 1'b1;
                    out_sum_q   <= acc_d;
                    out_count_q <= cnt_d;
                    out_ovf_q   <= ovf_d;
                    state_q     <= EMPTY;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                end else begin
                    state_q <= PARTIAL;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mmul_dot_accumulator.sv
// Bench for mmul_dot_accumulator: a 24-bit and a 12-bit accumulator share
// one stimulus stream and are checked against an arithmetic group model.
module tb_mmul_dot_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in_valid  = 1'b0;
    logic [9:0] in_prod   = '0;
    logic       in_last   = 1'b0;
    logic       acc_clr   = 1'b0;
    logic       out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] s24;
        logic [11:0] s12;
        logic [7:0]  cnt;
        logic        o24;
        logic        o12;
    } res_t;

    int   grp[$];
    res_t exp_q[$];
    bit   mdl_ov = 1'b0;

    mmul_dot_accumulator_if #(.RES_WIDTH(10), .ACC_WIDTH(24), .CNT_WIDTH(8)) ua ();
    mmul_dot_accumulator_if #(.RES_WIDTH(10), .ACC_WIDTH(12), .CNT_WIDTH(8)) ub ();

    assign ua.in_valid  = in_valid;
    assign ua.in_prod   = in_prod;
    assign ua.in_last   = in_last;
    assign ua.acc_clr   = acc_clr;
    assign ua.out_ready = out_ready;
    assign ub.in_valid  = in_valid;
    assign ub.in_prod   = in_prod;
    assign ub.in_last   = in_last;
    assign ub.acc_clr   = acc_clr;
    assign ub.out_ready = out_ready;

    mmul_dot_accumulator #(.RES_WIDTH(10), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ua.slave)
    );

    mmul_dot_accumulator #(.RES_WIDTH(10), .ACC_WIDTH(12), .CNT_WIDTH(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ub.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wrap a true integer into a W-bit two's-complement value.
    function automatic longint wrapw(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = ((v % m) + m) % m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Fold one group at width w: sum mod 2^w, overflow if any running sum left range.
    function automatic void fold(input int w, output longint s, output bit o);
        longint t;
        longint hi;
        hi = (longint'(1) << (w - 1)) - 1;
        s = 0;
        o = 1'b0;
        foreach (grp[i]) begin
            t = s + grp[i];
            if (t > hi || t < -hi - 1) o = 1'b1;
            s = wrapw(t, w);
        end
    endfunction

    function automatic res_t model();
        res_t   r;
        longint s;
        bit     o;
        fold(24, s, o);
        r.s24 = s[23:0];
        r.o24 = o;
        fold(12, s, o);
        r.s12 = s[11:0];
        r.o12 = o;
        r.cnt = (grp.size() > 255) ? 8'd255 : 8'(grp.size());
        return r;
    endfunction

    task automatic step(input bit v, input int p, input bit l, input bit c, input bit o);
        bit   exp_rdy;
        bit   xfer;
        res_t r;
        in_valid  = v;
        in_prod   = p[9:0];
        in_last   = l;
        acc_clr   = c;
        out_ready = o;
        #1;
        exp_rdy = !mdl_ov || o;
        chk("rdy_a", 32'(ua.in_ready), 32'(exp_rdy));
        chk("rdy_b", 32'(ub.in_ready), 32'(exp_rdy));
        chk("ov_a", 32'(ua.out_valid), 32'(mdl_ov));
        chk("ov_b", 32'(ub.out_valid), 32'(mdl_ov));
        xfer = mdl_ov && o;
        if (xfer && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("sum_a", 32'(ua.out_sum), 32'(r.s24));
            chk("sum_b", 32'(ub.out_sum), 32'(r.s12));
            chk("cnt_a", 32'(ua.out_count), 32'(r.cnt));
            chk("cnt_b", 32'(ub.out_count), 32'(r.cnt));
            chk("ovf_a", 32'(ua.out_ovf), 32'(r.o24));
            chk("ovf_b", 32'(ub.out_ovf), 32'(r.o12));
        end
        if (xfer) mdl_ov = 1'b0;
        if (c) begin
            grp.delete();
        end else if (v && exp_rdy) begin
            grp.push_back(p);
            if (l) begin
                exp_q.push_back(model());
                grp.delete();
                mdl_ov = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        grp.delete();
        exp_q.delete();
        mdl_ov = 1'b0;
        chk("rst_ov", 32'(ua.out_valid), 32'd0);
        chk("rst_sum", 32'(ua.out_sum), 32'd0);
        chk("rst_cnt", 32'(ua.out_count), 32'd0);
        chk("rst_ovf", 32'(ua.out_ovf), 32'd0);
        chk("rst_rdy", 32'(ua.in_ready), 32'd1);
    endtask

    initial begin
        int p;
        @(negedge clk);
        do_reset();

        step(1, 7, 0, 0, 1);
        step(1, -3, 0, 0, 1);
        step(1, 25, 0, 0, 1);
        step(1, -1, 1, 0, 1);
        chk("g1_sum", 32'(ua.out_sum), 32'd28);
        chk("g1_cnt", 32'(ua.out_count), 32'd4);
        step(0, 0, 0, 0, 1);
        chk("g1_clr", 32'(ua.out_valid), 32'd0);

        step(1, -512, 1, 0, 0);
        chk("single_sum", 32'(ua.out_sum), 32'h00FFFE00);
        chk("single_cnt", 32'(ua.out_count), 32'd1);
        step(0, 0, 0, 0, 1);

        step(1, 2, 0, 0, 0);
        step(1, 3, 1, 0, 0);
        step(1, 7, 0, 0, 0);
        step(1, 7, 0, 0, 0);
        chk("hold_sum", 32'(ua.out_sum), 32'd5);
        chk("hold_rdy", 32'(ua.in_ready), 32'd0);
        step(1, 7, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        chk("b_sum", 32'(ua.out_sum), 32'd8);
        step(0, 0, 0, 0, 1);

        step(1, 3, 1, 0, 1);
        step(1, 4, 1, 0, 1);
        step(1, 5, 1, 0, 1);
        chk("b2b_sum", 32'(ua.out_sum), 32'd5);
        step(0, 0, 0, 0, 1);

        for (int i = 0; i < 9; i++) step(1, 511, i == 8, 0, 1);
        chk("ovf12_sum", 32'(ub.out_sum), 32'd503);
        chk("ovf12_flag", 32'(ub.out_ovf), 32'd1);
        chk("ovf24_sum", 32'(ua.out_sum), 32'd4599);
        step(1, 1, 1, 0, 1);
        chk("ovf12_next", 32'(ub.out_ovf), 32'd0);
        step(0, 0, 0, 0, 1);

        step(1, 9, 0, 0, 1);
        step(1, 9, 0, 1, 1);
        step(1, 2, 0, 0, 1);
        step(1, 3, 1, 0, 1);
        chk("clr_sum", 32'(ua.out_sum), 32'd5);
        chk("clr_cnt", 32'(ua.out_count), 32'd2);

        step(1, 6, 1, 0, 0);
        do_reset();
        chk("rst_mid_ov", 32'(ua.out_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       p = 511;
                1:       p = -512;
                default: p = int'($urandom_range(0, 1023)) - 512;
            endcase
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 300; i++) step(1, 1, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        chk("cnt_sat", 32'(ua.out_count), 32'd255);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
